nibble_serial_addsub: RTL and testbench
=======================================

NIBBLE_SERIAL_ADDSUB -- requirements
Module: nibble_serial_addsub

Interface
REQ-001 Parameter: NIBBLES, 4, number of 4-bit nibbles per operand; operand width W = 4*NIBBLES.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  block can accept a request.
REQ-007 op_a  in  W  operand A.
REQ-008 op_b  in  W  operand B.
REQ-009 op_sub  in  1  0 = A+B, 1 = A-B.
REQ-010 nib_a  out  4  A nibble to the external 4-bit adder-subtractor.
REQ-011 nib_b  out  4  uninverted B nibble to the adder; the adder inverts B when nib_m=1.
REQ-012 nib_cin  out  1  carry into the current nibble.
REQ-013 nib_m  out  1  mode to the adder (latched op_sub).
REQ-014 nib_active  out  1  nib_* outputs are valid this cycle.
REQ-015 nib_sum  in  4  adder sum, combinational from nib_*, same cycle.
REQ-016 nib_carry  in  1  adder carry-out, same cycle.
REQ-017 res_valid  out  1  result available.
REQ-018 res_ready  in  1  consumer accepts the result.
REQ-019 res_sum  out  W  result.
REQ-020 res_carry  out  1  final carry-out; for subtract, 1 = no borrow.
REQ-021 res_ovf  out  1  signed two's-complement overflow.
REQ-022 res_zero  out  1  res_sum == 0.

Function
REQ-023 FSM states: IDLE, RUN, DONE; req_ready=1 only in IDLE, res_valid=1 only in DONE, nib_active=1 only in RUN.
REQ-024 IDLE: on req_valid=1, latch op_a, op_b, op_sub; set idx=0 and carry_reg=op_sub; clear the result register; go to RUN.
REQ-025 RUN: drive nib_a=A[4*idx+:4], nib_b=B[4*idx+:4], nib_cin=carry_reg, nib_m=sub.
REQ-026 RUN, each cycle: store nib_sum into result[4*idx+:4]; set carry_reg<=nib_carry; increment idx.
REQ-027 RUN: go to DONE in the cycle idx=NIBBLES-1; no idx wrap is ever visible.
REQ-028 Latency: acceptance edge to res_valid=1 is NIBBLES+1 rising edges (5 for the default).
REQ-029 Outside RUN, nib_a, nib_b, nib_cin and nib_m SHALL be 0.
REQ-030 DONE: res_* stay stable until res_valid&&res_ready; on that edge go to IDLE.
REQ-031 A new request is accepted one cycle after the result handshake at the earliest; requests never overlap.
REQ-032 req_valid in RUN or DONE is ignored; the caller holds it until req_ready.
REQ-033 res_ovf, add: A[W-1]==B[W-1] and S[W-1]!=A[W-1].
REQ-034 res_ovf, sub: A[W-1]!=B[W-1] and S[W-1]!=A[W-1].
REQ-035 res_carry = carry_reg at entry to DONE; res_zero is computed from the stored result.

Reset
REQ-036 rst_n=0 immediately forces state=IDLE and clears idx, carry_reg, the latched operands, the result and all flags; every output reads 0 except req_ready, which reads 1.
REQ-037 Reset during RUN or DONE abandons the operation with no result handshake; the first post-reset request behaves normally.

Structure
REQ-038 Package addsub_pkg holds the FSM state enum and the constant NIBBLE_W=4.
REQ-039 One sub-module, addsub_flags (combinational: sign bits, sub and sum to ovf and zero); the nibble adder stays external.

Verification
REQ-040 The bench provides a behavioural 4-bit adder-subtractor model on the nib_* ports.
REQ-041 add 0x1234+0x4321 -> res_sum 0x5555, carry 0, ovf 0, zero 0; res_valid exactly 5 cycles after acceptance.
REQ-042 add 0xFFFF+0x0001 -> res_sum 0x0000, carry 1, zero 1, ovf 0; add 0x7FFF+0x0001 -> 0x8000, ovf 1, carry 0.
REQ-043 sub 0x0005-0x0007 -> 0xFFFE, carry 0, ovf 0; sub 0x8000-0x0001 -> 0x7FFF, ovf 1, carry 1; first RUN cycle shows nib_cin=1, nib_m=1.
REQ-044 res_ready held 0 for 3 cycles in DONE -> res_* stable, req_ready 0, a pending req_valid is not accepted; it is accepted the cycle after the handshake.
REQ-045 rst_n pulsed low in the 2nd RUN cycle -> all outputs 0, req_ready 1 asynchronously; the next request 0x0001+0x0001 returns 0x0002.

Source files
------------

// File: rtl/nibble_serial_addsub_pkg.sv
// ============================================================================
// addsub_pkg: shared constants and FSM state encoding for nibble_serial_addsub
// Revision 1.0
// ============================================================================
`default_nettype none

package addsub_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/nibble_serial_addsub_flags.sv
// ============================================================================
// addsub_flags: signed-overflow and zero detection for the serial add/sub result
// Revision 1.0
// ============================================================================
`default_nettype none

module addsub_flags
  import addsub_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         a_msb_i,
  input  logic         b_msb_i,
  input  logic         sub_i,
  input  logic [W-1:0] sum_i,
  output logic         ovf_o,
  output logic         zero_o
);

  logic w_operands_agree;

  // Subtraction flips B, so overflow needs opposite-signed operands there.
  always_comb begin
    w_operands_agree = sub_i ? (a_msb_i != b_msb_i) : (a_msb_i == b_msb_i);
    ovf_o            = w_operands_agree && (sum_i[W-1] != a_msb_i);
    zero_o           = (sum_i == '0);
  end

endmodule

`default_nettype wire

// File: rtl/nibble_serial_addsub.sv
// ============================================================================
// nibble_serial_addsub: W-bit add/subtract computed one nibble per cycle
// through an external 4-bit adder-subtractor. Revision 1.0
// ============================================================================
`default_nettype none

module nibble_serial_addsub
  import addsub_pkg::*;
#(
  parameter int NIBBLES = 4,
  parameter int W       = NIBBLE_W * NIBBLES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [W-1:0]        op_a,
  input  logic [W-1:0]        op_b,
  input  logic                op_sub,
  output logic [NIBBLE_W-1:0] nib_a,
  output logic [NIBBLE_W-1:0] nib_b,
  output logic                nib_cin,
  output logic                nib_m,
  output logic                nib_active,
  input  logic [NIBBLE_W-1:0] nib_sum,
  input  logic                nib_carry,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [W-1:0]        res_sum,
  output logic                res_carry,
  output logic                res_ovf,
  output logic                res_zero
);

  localparam int                IDX_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     res_q, res_d;

  logic             w_ovf;
  logic             w_zero;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid)          state_d = ST_RUN;
      ST_RUN:  if (idx_q == LAST_IDX)  state_d = ST_DONE;
      ST_DONE: if (res_ready)          state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  // Datapath: carry starts at op_sub so the adder's inverted B forms two's complement.
  always_comb begin
    idx_d   = idx_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          sub_d   = op_sub;
          idx_d   = '0;
          carry_d = op_sub;
          res_d   = '0;
        end
      end
      ST_RUN: begin
        res_d[NIBBLE_W*idx_q +: NIBBLE_W] = nib_sum;
        carry_d = nib_carry;
        if (idx_q != LAST_IDX) begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  addsub_flags #(
    .W (W)
  ) u_flags (
    .a_msb_i (a_q[W-1]),
    .b_msb_i (b_q[W-1]),
    .sub_i   (sub_q),
    .sum_i   (res_q),
    .ovf_o   (w_ovf),
    .zero_o  (w_zero)
  );

  // Output logic
  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    nib_active = (state_q == ST_RUN);
    res_valid  = (state_q == ST_DONE);
    nib_a      = '0;
    nib_b      = '0;
    nib_cin    = 1'b0;
    nib_m      = 1'b0;
    res_sum    = '0;
    res_carry  = 1'b0;
    res_ovf    = 1'b0;
    res_zero   = 1'b0;
    if (state_q == ST_RUN) begin
      nib_a   = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
      nib_b   = b_q[NIBBLE_W*idx_q +: NIBBLE_W];
      nib_cin = carry_q;
      nib_m   = sub_q;
    end
    if (state_q == ST_DONE) begin
      res_sum   = res_q;
      res_carry = carry_q;
      res_ovf   = w_ovf;
      res_zero  = w_zero;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_addsub.sv
// ============================================================================
// tb_nibble_serial_addsub: vector table, random ops and corner sequences
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_nibble_serial_addsub;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         op_sub = 1'b0;
  logic [3:0]   nib_a, nib_b, nib_sum;
  logic         nib_cin, nib_m, nib_active, nib_carry;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_sum;
  logic         res_carry, res_ovf, res_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // External 4-bit adder-subtractor: B is inverted in subtract mode.
  logic [4:0] adder_out;
  assign adder_out = {1'b0, nib_a} + {1'b0, (nib_m ? ~nib_b : nib_b)} + {4'd0, nib_cin};
  assign nib_sum   = adder_out[3:0];
  assign nib_carry = adder_out[4];

  nibble_serial_addsub #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .op_a(op_a), .op_b(op_b), .op_sub(op_sub),
    .nib_a(nib_a), .nib_b(nib_b), .nib_cin(nib_cin), .nib_m(nib_m),
    .nib_active(nib_active), .nib_sum(nib_sum), .nib_carry(nib_carry),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_carry(res_carry), .res_ovf(res_ovf), .res_zero(res_zero)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] s;
    logic         c;
    logic         o;
    logic         z;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the full operands.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       output logic [W-1:0] s, output logic c, output logic o, output logic z);
    int sa, sb, tr;
    logic [W:0] r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      r  = {1'b0, a} - {1'b0, b};
      c  = (a >= b);
      tr = sa - sb;
    end else begin
      r  = {1'b0, a} + {1'b0, b};
      c  = r[W];
      tr = sa + sb;
    end
    s = r[W-1:0];
    o = (tr > 32767) || (tr < -32768);
    z = (s == '0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    if (!req_ready) chk({name, "_ready_timeout"}, 32'(req_ready), 32'd1);
  endtask

  // Drives one request, checks first RUN cycle, latency and idle nib outputs in DONE.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, output logic [W-1:0] s, output logic c,
                        output logic o, output logic z);
    int cyc;
    wait_ready(name);
    op_a = a; op_b = b; op_sub = sub; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    cyc = 1;
    chk({name, "_run0"}, {27'd0, nib_active, nib_cin, nib_m, 2'b00},
        {27'd0, 1'b1, sub, sub, 2'b00});
    chk({name, "_nib0"}, {24'd0, nib_a, nib_b}, {24'd0, a[3:0], b[3:0]});
    while (!res_valid && cyc < 20) begin tick(); cyc++; end
    chk({name, "_latency"}, 32'(cyc), 32'd5);
    chk({name, "_idle_nib"}, {21'd0, nib_a, nib_b, nib_cin, nib_m, nib_active},
        32'd0);
    s = res_sum; c = res_carry; o = res_ovf; z = res_zero;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({name, "_back_idle"}, {30'd0, req_ready, res_valid}, {30'd0, 1'b1, 1'b0});
  endtask

  vec_t tbl[6];

  initial begin
    logic [W-1:0] gs, ms, held_s, a, b;
    logic gc, go, gz, mc, mo, mz, sub;
    int cyc;

    tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};

    // Asynchronous reset, observed before any clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("reset_outputs",
        {nib_a, nib_b, nib_cin, nib_m, nib_active, res_valid, res_carry, res_ovf, res_zero},
        17'd0);
    chk("reset_sum", 32'(res_sum), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    foreach (tbl[i]) begin
      run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].sub, gs, gc, go, gz);
      chk($sformatf("vec%0d_sum", i), 32'(gs), 32'(tbl[i].s));
      chk($sformatf("vec%0d_flags", i), {29'd0, gc, go, gz},
          {29'd0, tbl[i].c, tbl[i].o, tbl[i].z});
    end

    for (int i = 0; i < 20; i++) begin
      a   = W'($urandom);
      b   = (i % 5 == 0) ? a : W'($urandom);
      sub = 1'($urandom);
      run_op($sformatf("rnd%0d", i), a, b, sub, gs, gc, go, gz);
      model(a, b, sub, ms, mc, mo, mz);
      chk($sformatf("rnd%0d_sum", i), 32'(gs), 32'(ms));
      chk($sformatf("rnd%0d_flags", i), {29'd0, gc, go, gz}, {29'd0, mc, mo, mz});
    end

    // Backpressure in DONE with a pending request
    run_op("bp_warm", 16'h0000, 16'h0000, 1'b0, gs, gc, go, gz);
    op_a = 16'h0102; op_b = 16'h0304; op_sub = 1'b0; req_valid = 1'b1;
    tick();
    op_a = 16'h0A0A; op_b = 16'h0101; op_sub = 1'b1;
    cyc = 1;
    while (!res_valid && cyc < 20) begin tick(); cyc++; end
    chk("bp_latency", 32'(cyc), 32'd5);
    held_s = res_sum;
    chk("bp_sum", 32'(held_s), 32'h0406);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("bp_hold%0d", k), {14'd0, res_valid, req_ready, res_sum},
          {14'd0, 1'b1, 1'b0, 16'h0406});
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("bp_idle_after_hs", {30'd0, req_ready, res_valid}, {30'd0, 1'b1, 1'b0});
    tick();
    req_valid = 1'b0;
    chk("bp_pending_accepted", {30'd0, nib_active, nib_m}, {30'd0, 1'b1, 1'b1});
    cyc = 1;
    while (!res_valid && cyc < 20) begin tick(); cyc++; end
    chk("bp2_sum", 32'(res_sum), 32'h0909);
    chk("bp2_flags", {29'd0, res_carry, res_ovf, res_zero}, {29'd0, 1'b1, 1'b0, 1'b0});
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // Reset pulsed in the second RUN cycle
    wait_ready("rst_mid");
    op_a = 16'hAAAA; op_b = 16'h5555; op_sub = 1'b0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    chk("rst_mid_in_run", 32'(nib_active), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs",
        {nib_a, nib_b, nib_cin, nib_m, nib_active, res_valid, res_carry, res_ovf, res_zero},
        17'd0);
    chk("rst_mid_ready_sum", {15'd0, req_ready, res_sum}, {15'd0, 1'b1, 16'h0000});
    tick();
    rst_n = 1'b1;
    tick();
    run_op("post_rst", 16'h0001, 16'h0001, 1'b0, gs, gc, go, gz);
    chk("post_rst_sum", 32'(gs), 32'h0002);
    chk("post_rst_flags", {29'd0, gc, go, gz}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
